// File: rtl/display7_pkg.sv
// display7_pkg: shared types and constants for the 7-segment readback path.
// Segment bit order is bit0=a ... bit6=g. All patterns are active-low (0 = lit).
// Optional feature macro (used by display7_seg2bin): DISPLAY7_READER_HEX_EN.
package display7_pkg;

  // Segment bit positions within a 7-bit pattern.
  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  // Active-low patterns, g..a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decode result: hit = recognised digit, blank = all segments dark.
  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] value;
  } seg_dec_t;

  function automatic seg_dec_t seg_hit(input logic [3:0] v);
    seg_dec_t d;
    d.hit   = 1'b1;
    d.blank = 1'b0;
    d.value = v;
    return d;
  endfunction

endpackage

// File: rtl/display7_reader_if.sv
// display7_reader_if: observed display bus (segments + anodes) and recovered digit state.
// Ports: iSeg/iAn driven by the display side (master), oDigits/oValid/oErr/oUpdate by the reader (slave).
// All signals are sampled/produced on the reader's clock; there is no handshake or backpressure.
interface display7_reader_if #(
  parameter int DIGITS = 8
);
  logic [6:0]          iSeg;
  logic [DIGITS-1:0]   iAn;
  logic [4*DIGITS-1:0] oDigits;
  logic [DIGITS-1:0]   oValid;
  logic [DIGITS-1:0]   oErr;
  logic                oUpdate;

  modport master (output iSeg, iAn, input oDigits, oValid, oErr, oUpdate);
  modport slave  (input iSeg, iAn, output oDigits, oValid, oErr, oUpdate);
endinterface

// File: rtl/display7_seg2bin.sv
// display7_seg2bin: combinational active-low 7-segment pattern to digit decoder.
// Ports: i_seg (7-bit pattern, bit0=a), o_dec (seg_dec_t: hit, blank, value). Zero latency.
// DISPLAY7_READER_HEX_EN adds A..F (values 10..15); otherwise those patterns are misses.
import display7_pkg::*;

module display7_seg2bin (
  input  logic [6:0] i_seg,
  output seg_dec_t   o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_seg)
      SEG_0:     o_dec = seg_hit(4'd0);
      SEG_1:     o_dec = seg_hit(4'd1);
      SEG_2:     o_dec = seg_hit(4'd2);
      SEG_3:     o_dec = seg_hit(4'd3);
      SEG_4:     o_dec = seg_hit(4'd4);
      SEG_5:     o_dec = seg_hit(4'd5);
      SEG_6:     o_dec = seg_hit(4'd6);
      SEG_7:     o_dec = seg_hit(4'd7);
      SEG_8:     o_dec = seg_hit(4'd8);
      SEG_9:     o_dec = seg_hit(4'd9);
`ifdef DISPLAY7_READER_HEX_EN
      SEG_A:     o_dec = seg_hit(4'd10);
      SEG_B:     o_dec = seg_hit(4'd11);
      SEG_C:     o_dec = seg_hit(4'd12);
      SEG_D:     o_dec = seg_hit(4'd13);
      SEG_E:     o_dec = seg_hit(4'd14);
      SEG_F:     o_dec = seg_hit(4'd15);
`endif
      SEG_BLANK: o_dec.blank = 1'b1;
      default:   o_dec = '0;
    endcase
  end

endmodule

// File: rtl/display7_reader.sv
// display7_reader: rebuilds per-digit values from a multiplexed active-low 7-segment bus.
// Ports: iClk, iRst_n (async active-low); bus.slave carries iSeg/iAn in, oDigits/oValid/oErr/oUpdate out.
// A pair held STABLE_CYCLES+1 edges is captured on the last of them; no backpressure, all outputs registered.
// Optional feature: DISPLAY7_READER_HEX_EN (hex A..F decode, see display7_seg2bin).
import display7_pkg::*;

module display7_reader #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  display7_reader_if.slave  bus
);

  localparam logic [7:0] L_SAT = 8'(STABLE_CYCLES);
  localparam logic [7:0] L_CAP = 8'(STABLE_CYCLES - 1);

  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_cnt;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_valid;
  logic [DIGITS-1:0]   r_err;
  logic                r_update;

  logic [DIGITS-1:0]   w_an_lo;
  logic                w_onehot;
  logic                w_match;
  logic                w_capture;
  logic                w_change;
  logic [4*DIGITS-1:0] w_digits_nxt;
  logic [DIGITS-1:0]   w_valid_nxt;
  logic [DIGITS-1:0]   w_err_nxt;
  seg_dec_t            w_dec;

  // Decode the registered pattern so the capture uses exactly the pair that was qualified.
  display7_seg2bin u_seg2bin (
    .i_seg (r_seg),
    .o_dec (w_dec)
  );

  assign w_an_lo   = ~r_an;
  assign w_onehot  = (w_an_lo != '0) && ((w_an_lo & (w_an_lo - DIGITS'(1))) == '0);
  assign w_match   = (bus.iSeg == r_seg) && (bus.iAn == r_an);
  // cnt reaches STABLE_CYCLES-1 only once per run and then saturates past it,
  // so a long hold yields a single capture.
  assign w_capture = w_match && w_onehot && (r_cnt == L_CAP);

  always_comb begin
    w_digits_nxt = r_digits;
    w_valid_nxt  = r_valid;
    w_err_nxt    = r_err;
    if (w_capture) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (!r_an[k]) begin
          if (w_dec.hit) begin
            w_digits_nxt[4*k +: 4] = w_dec.value;
            w_valid_nxt[k]         = 1'b1;
            w_err_nxt[k]           = 1'b0;
          end else begin
            // Blank clears both flags; anything else is an error. Digit value is kept.
            w_valid_nxt[k] = 1'b0;
            w_err_nxt[k]   = !w_dec.blank;
          end
        end
      end
    end
  end

  // A capture that reproduces the current state is silent.
  assign w_change = (w_digits_nxt != r_digits) || (w_valid_nxt != r_valid) ||
                    (w_err_nxt != r_err);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_seg    <= SEG_BLANK;
      r_an     <= '1;
      r_cnt    <= 8'd0;
      r_digits <= '0;
      r_valid  <= '0;
      r_err    <= '0;
      r_update <= 1'b0;
    end else begin
      r_seg <= bus.iSeg;
      r_an  <= bus.iAn;
      if (!w_match || !w_onehot) begin
        r_cnt <= 8'd0;
      end else if (r_cnt != L_SAT) begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_digits <= w_digits_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
      r_update <= w_change;
    end
  end

  assign bus.oDigits = r_digits;
  assign bus.oValid  = r_valid;
  assign bus.oErr    = r_err;
  assign bus.oUpdate = r_update;

endmodule

// File: tb/tb_display7_reader.sv
// tb_display7_reader: directed scoreboard bench for display7_reader (DIGITS=4, STABLE_CYCLES=3).
// A small reference model pushes the expected output state whenever a capturing hold is driven;
// each oUpdate pulse pops and compares one entry.
module tb_display7_reader;

  localparam int S = 3;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  vld;
    logic [3:0]  err;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];

  int n_total;
  int n_pass;
  int n_upd;
  int n_upd_exp;

  logic [15:0] m_dig;
  logic [3:0]  m_vld;
  logic [3:0]  m_err;

  display7_reader_if #(.DIGITS(4)) bus ();

  display7_reader #(
    .DIGITS        (4),
    .STABLE_CYCLES (S)
  ) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference decode: returns {hit, blank, value}.
  function automatic logic [5:0] ref_dec(input logic [6:0] seg);
    case (seg)
      7'h40: return {2'b10, 4'd0};
      7'h79: return {2'b10, 4'd1};
      7'h24: return {2'b10, 4'd2};
      7'h30: return {2'b10, 4'd3};
      7'h19: return {2'b10, 4'd4};
      7'h12: return {2'b10, 4'd5};
      7'h02: return {2'b10, 4'd6};
      7'h78: return {2'b10, 4'd7};
      7'h00: return {2'b10, 4'd8};
      7'h10: return {2'b10, 4'd9};
`ifdef DISPLAY7_READER_HEX_EN
      7'h08: return {2'b10, 4'd10};
      7'h03: return {2'b10, 4'd11};
      7'h46: return {2'b10, 4'd12};
      7'h21: return {2'b10, 4'd13};
      7'h06: return {2'b10, 4'd14};
      7'h0E: return {2'b10, 4'd15};
`endif
      7'h7F: return {2'b01, 4'd0};
      default: return 6'd0;
    endcase
  endfunction

  // One clock; sample #1 after the edge and retire an expected entry on oUpdate.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.oUpdate === 1'b1) begin
      n_upd++;
      chk("upd_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("upd_digits", 32'(bus.oDigits), 32'(e.dig));
        chk("upd_valid",  32'(bus.oValid),  32'(e.vld));
        chk("upd_err",    32'(bus.oErr),    32'(e.err));
      end
    end
  endtask

  // Hold a (seg, an) pair for n edges; the pair must differ from the previous one.
  task automatic hold(input logic [6:0] seg, input logic [3:0] an, input int n, input string tag);
    logic        will;
    logic [5:0]  d;
    int          k;
    logic [15:0] nd;
    logic [3:0]  nv;
    logic [3:0]  ne;
    exp_t        e;
    will = 1'b0;
    nd = m_dig;
    nv = m_vld;
    ne = m_err;
    k = 0;
    if (n >= S + 1 && $countones(~an) == 1) begin
      for (int j = 0; j < 4; j++) if (!an[j]) k = j;
      d = ref_dec(seg);
      if (d[5]) begin
        nd[4*k +: 4] = d[3:0];
        nv[k] = 1'b1;
        ne[k] = 1'b0;
      end else begin
        nv[k] = 1'b0;
        ne[k] = !d[4];
      end
      if (nd != m_dig || nv != m_vld || ne != m_err) begin
        e.dig = nd;
        e.vld = nv;
        e.err = ne;
        q.push_back(e);
        n_upd_exp++;
        m_dig = nd;
        m_vld = nv;
        m_err = ne;
        will = 1'b1;
      end
    end
    bus.iSeg = seg;
    bus.iAn  = an;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (will && i == S - 1) chk({tag, "_not_early"}, 32'(q.size()), 32'd1);
    end
    if (will) chk({tag, "_captured"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    n_total = 0;
    n_pass = 0;
    n_upd = 0;
    n_upd_exp = 0;
    m_dig = '0;
    m_vld = '0;
    m_err = '0;
    rst_n = 1'b0;
    bus.iSeg = 7'h7F;
    bus.iAn  = 4'hF;

    // Reset state
    repeat (3) cyc();
    chk("rst_digits", 32'(bus.oDigits), 32'h0);
    chk("rst_valid",  32'(bus.oValid),  32'h0);
    chk("rst_err",    32'(bus.oErr),    32'h0);
    chk("rst_update", 32'(bus.oUpdate), 32'h0);
    #2 rst_n = 1'b1;
    cyc();

    // Ghost reject: a 2-edge flash of 5 is never captured; 0 is
    hold(7'h12, 4'b1110, 2, "ghost5");
    hold(7'h40, 4'b1110, 4, "ghost0");
    chk("ghost_valid", 32'(bus.oValid), 32'h1);
    chk("ghost_dig0",  32'(bus.oDigits[3:0]), 32'h0);

    // Clean scan
    hold(7'h24, 4'b1110, 4, "scan2");
    hold(7'h12, 4'b1101, 4, "scan5");
    chk("scan_digits", 32'(bus.oDigits), 32'h0052);
    chk("scan_valid",  32'(bus.oValid),  32'h3);

    // Bad pattern, hex A (error or value depending on build), then blank
    hold(7'h7E, 4'b1011, 4, "bad");
    chk("bad_err",    32'(bus.oErr),            32'h4);
    chk("bad_valid2", 32'(bus.oValid[2]),       32'h0);
    chk("bad_dig2",   32'(bus.oDigits[11:8]),   32'h0);
    hold(7'h08, 4'b1011, 4, "hexA");
    chk("hexA_dig2",  32'(bus.oDigits[11:8]),   32'(m_dig[11:8]));
    chk("hexA_err",   32'(bus.oErr),            32'(m_err));
    hold(7'h7F, 4'b1011, 4, "blank");
    chk("blank_err",  32'(bus.oErr),            32'h0);
    chk("blank_vld",  32'(bus.oValid),          32'h3);

    // Illegal anodes: two low, then none low
    hold(7'h00, 4'b1100, 10, "two_an");
    hold(7'h00, 4'b1111, 6, "no_an");
    chk("illegal_digits", 32'(bus.oDigits), 32'(m_dig));
    chk("illegal_valid",  32'(bus.oValid),  32'h3);

    // Repeat: identical rescan of digit 3 produces no second update
    hold(7'h79, 4'b0111, 4, "rep1");
    hold(7'h40, 4'b1110, 4, "rep_mid");
    hold(7'h79, 4'b0111, 4, "rep2");
    chk("rep_digits", 32'(bus.oDigits), 32'(m_dig));
    chk("rep_dig3",   32'(bus.oDigits[15:12]), 32'h1);

    // Reset mid-run: outputs clear asynchronously, then a fresh full run is required
    bus.iSeg = 7'h30;
    bus.iAn  = 4'b1101;
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", 32'(bus.oDigits), 32'h0);
    chk("mid_rst_valid",  32'(bus.oValid),  32'h0);
    chk("mid_rst_err",    32'(bus.oErr),    32'h0);
    chk("mid_rst_update", 32'(bus.oUpdate), 32'h0);
    m_dig = '0;
    m_vld = '0;
    m_err = '0;
    repeat (2) cyc();
    #2 rst_n = 1'b1;
    e.dig = 16'h0030;
    e.vld = 4'b0010;
    e.err = 4'b0000;
    q.push_back(e);
    n_upd_exp++;
    for (int i = 0; i < S + 1; i++) begin
      cyc();
      if (i == S - 1) chk("post_rst_not_early", 32'(q.size()), 32'd1);
    end
    chk("post_rst_captured", 32'(q.size()), 32'd0);
    chk("post_rst_digits",   32'(bus.oDigits), 32'h0030);

    repeat (2) cyc();
    chk("queue_empty",  32'(q.size()), 32'd0);
    chk("update_count", 32'(n_upd),    32'(n_upd_exp));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/display7_reader.md
# display7_reader

Recovers per-digit values from a multiplexed, active-low 7-segment display bus. This is the inverse of the team's digit-to-segment decoder. It sits on the observation side of the display path, watches the anode strobes and segment lines, and rebuilds the digit contents for self-check, scan-chain readback and the verification scoreboards. The block filters ghosting with a stability qualifier and flags segment patterns it cannot decode.

## Interface
Parameters:
- DIGITS, 8: number of multiplexed digit positions (anode lines), 1..16.
- STABLE_CYCLES, 4: consecutive cycles an anode/segment pair must hold before it is captured, 1..255.

Ports (clock is iClk; reset is iRst_n, asynchronous, active-low):
- iClk  in  1  system clock, all state on rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iSeg  in  7  segment lines, active-low, bit0=a … bit6=g.
- iAn  in  DIGITS  anode enables, active-low; legal when exactly one bit is low.
- oDigits  out  4*DIGITS  recovered value; digit k occupies bits [4k+3:4k].
- oValid  out  DIGITS  digit k holds a decoded value.
- oErr  out  DIGITS  last capture for digit k was an undecodable pattern.
- oUpdate  out  1  one-cycle pulse when any capture changes oDigits, oValid or oErr.

## Operation
- Input stage: iSeg and iAn are registered every cycle into rSeg and rAn.
- Run counter cnt, width 8:
  - Cleared when {iSeg, iAn} differs from {rSeg, rAn}, or when rAn is not one-hot-low.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture fires when cnt == STABLE_CYCLES-1, the inputs still match, and rAn is one-hot-low. There is exactly one capture per run.
- Decode table (hex, active-low, g..a): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- On capture for digit k:
  - Table hit: oDigits[k] = value, oValid[k] = 1, oErr[k] = 0.
  - Blank pattern 7F: oValid[k] = 0, oErr[k] = 0, oDigits[k] unchanged.
  - Any other pattern: oValid[k] = 0, oErr[k] = 1, oDigits[k] unchanged.
- oUpdate asserts for one cycle coincident with output registers that changed. A capture that reproduces the current state does not pulse oUpdate.
- All anodes high, or multiple anodes low: no capture; cnt held at 0.
- Reset values: rSeg = 7F, rAn = all ones, cnt = 0, oDigits = 0, oValid = 0, oErr = 0, oUpdate = 0.
- Reset mid-run: the run is discarded, and the first capture after release needs a full new run.

## Timing
- Let E0 be the first edge at which a new legal pair is present on the inputs.
- If the pair is held at E0 … E(STABLE_CYCLES), outputs update at edge E(STABLE_CYCLES), and oUpdate is high for the following cycle.
- If the pair breaks at any edge before E(STABLE_CYCLES), no capture occurs and a new run starts at that edge.
- STABLE_CYCLES = 1: the pair must be present at two consecutive edges.
- No combinational path from input to output; all outputs are registered.
- Simultaneous anode change and segment change count as one break.

## Configuration
- DISPLAY7_READER_HEX_EN defined: the table additionally accepts A=08, b=03, C=46, d=21, E=06, F=0E, mapping to values 10..15 with oValid = 1.
- Not defined: those six patterns set oErr and leave the digit unchanged.

## Structure
- Package display7_pkg holds:
  - SEG_0 … SEG_9, SEG_A … SEG_F and SEG_BLANK constants (7-bit, active-low).
  - The segment bit-order definition.
  - seg_dec_t, a struct {hit, blank, value[3:0]}.
- Sub-module display7_seg2bin is combinational and maps a 7-bit pattern to seg_dec_t. It contains the full table and the HEX_EN branch.
- The top module contains the input stage, run counter, one-hot check, per-digit registers and update compare.

## Test plan
Each scenario uses DIGITS=4, STABLE_CYCLES=3.
- Reset: assert iRst_n low mid-run. All outputs go to 0 immediately; after release, the held pair is captured only after a fresh 4-edge run.
- Clean scan: iAn=1110 with iSeg=24 for 4 edges, then iAn=1101 with iSeg=12 for 4 edges. Result: oDigits[3:0]=2 and [7:4]=5, oValid=0011, two oUpdate pulses.
- Ghost reject: iAn=1110 with iSeg=24 for 2 edges, then iSeg=40. Result: no capture of 2; digit 0 becomes 0 after 4 edges of 40.
- Bad pattern: iAn=1011 with iSeg=7E held for 4 edges. Result: oErr[2]=1, oValid[2]=0, oDigits[11:8] unchanged. With HEX_EN, 08 gives value A and oValid[2]=1.
- Illegal anode: iAn=1100 with iSeg=00 held for 10 cycles. Result: no capture and no oUpdate.
- Repeat: rescanning an identical value (79 on digit 3 twice, with a different digit scanned between) produces a second capture with no second oUpdate.
